// File: rtl/div_pkg.sv
// Shared definitions for the iterative RV32M divide/remainder unit.
// Holds the default data width, funct3[1:0] op encodings, the sequencer
// state encoding and the signed-overflow operand constants.
package div_pkg;

    localparam int DIV_XLEN = 32;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [DIV_XLEN-1:0] INT_MIN = 32'h8000_0000;
    localparam logic [DIV_XLEN-1:0] NEG_ONE = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step of an unsigned divide.
// Ports:
//   rem_i / rem_o : partial remainder in / out (XLEN+1 bits)
//   quo_i / quo_o : dividend being shifted out / quotient shifted in
//   dvs_i         : divisor magnitude
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] dvs_i,
    output logic [XLEN:0]   rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN+1:0] shifted;
    logic [XLEN+1:0] trial;

    always_comb begin
        // One extra bit above the remainder so the trial subtract's sign is
        // never lost to wrap-around.
        shifted = {rem_i, quo_i[XLEN-1]};
        trial   = shifted - {2'b00, dvs_i};
        if (!trial[XLEN+1]) begin
            rem_o = trial[XLEN:0];
            quo_o = {quo_i[XLEN-2:0], 1'b1};
        end else begin
            rem_o = shifted[XLEN:0];
            quo_o = {quo_i[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle sequencer for DIV/DIVU/REM/REMU in the EXE stage.
// Holds stall while iterating, pulses done for one cycle with the result.
// Divide-by-zero and signed overflow finish one cycle after start.
// Ports:
//   clk, nrst          : clock, asynchronous active-high reset
//   start, op, opa, opb: divide request from EXE (op = funct3[1:0])
//   kill               : abort current op, return to IDLE without done
//   stall, busy, done  : stall request, not-idle, one-cycle result valid
//   result             : quotient/remainder, held until the next done
//
// state | meaning
// IDLE  | waiting for start; captures operands, detects special cases
// BUSY  | BITS_PER_CYCLE restoring steps per cycle, counter counts down
// DONE  | done pulse, sign-corrected result presented, pipeline advances
module div_sequencer
    import div_pkg::*;
#(
    parameter int XLEN           = DIV_XLEN,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] opa,
    input  logic [XLEN-1:0] opb,
    input  logic            kill,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int ITER  = XLEN / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(XLEN);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN:0]     rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   dvs_q, dvs_d;
    logic              sel_rem_q, sel_rem_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              is_signed, sel_rem;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_zero, ovf;
    logic [XLEN-1:0]   res_raw, res_fix;
    logic              res_neg;

    logic [XLEN:0]     rem_chain [BITS_PER_CYCLE+1];
    logic [XLEN-1:0]   quo_chain [BITS_PER_CYCLE+1];

    assign rem_chain[0] = rem_q;
    assign quo_chain[0] = quo_q;

    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
        div_step #(.XLEN(XLEN)) u_step (
            .rem_i (rem_chain[i]),
            .quo_i (quo_chain[i]),
            .dvs_i (dvs_q),
            .rem_o (rem_chain[i+1]),
            .quo_o (quo_chain[i+1])
        );
    end

    always_comb begin
        is_signed = 1'b0;
        sel_rem   = 1'b0;
        case (op)
            OP_DIV:  begin is_signed = 1'b1; sel_rem = 1'b0; end
            OP_DIVU: begin is_signed = 1'b0; sel_rem = 1'b0; end
            OP_REM:  begin is_signed = 1'b1; sel_rem = 1'b1; end
            OP_REMU: begin is_signed = 1'b0; sel_rem = 1'b1; end
            default: ;
        endcase
        a_neg    = is_signed & opa[XLEN-1];
        b_neg    = is_signed & opb[XLEN-1];
        a_mag    = a_neg ? -opa : opa;
        b_mag    = b_neg ? -opb : opb;
        div_zero = (opb == '0);
        ovf      = is_signed && (opa == INT_MIN) && (opb == NEG_ONE);

        res_raw  = sel_rem_q ? rem_q[XLEN-1:0] : quo_q;
        res_neg  = sel_rem_q ? neg_rem_q : neg_quo_q;
        res_fix  = res_neg ? -res_raw : res_raw;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        sel_rem_d = sel_rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        stall     = 1'b0;
        done      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !kill) begin
                    stall     = 1'b1;
                    sel_rem_d = sel_rem;
                    state_d   = DONE;
                    // Special cases load their final values directly, with
                    // sign correction disabled.
                    if (div_zero) begin
                        quo_d     = '1;
                        rem_d     = {1'b0, opa};
                        neg_quo_d = 1'b0;
                        neg_rem_d = 1'b0;
                    end else if (ovf) begin
                        quo_d     = INT_MIN;
                        rem_d     = '0;
                        neg_quo_d = 1'b0;
                        neg_rem_d = 1'b0;
                    end else begin
                        rem_d     = '0;
                        quo_d     = a_mag;
                        dvs_d     = b_mag;
                        neg_quo_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        cnt_d     = CNT_W'(ITER - 1);
                        state_d   = BUSY;
                    end
                end
            end
            BUSY: begin
                if (kill) begin
                    state_d = IDLE;
                end else begin
                    stall = 1'b1;
                    rem_d = rem_chain[BITS_PER_CYCLE];
                    quo_d = quo_chain[BITS_PER_CYCLE];
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                if (!kill) begin
                    done     = 1'b1;
                    result_d = res_fix;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The DONE cycle shows the freshly corrected value; otherwise the last
    // committed result is held.
    assign result = done ? res_fix : result_q;
    assign busy   = (state_q != IDLE);

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            sel_rem_q <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            sel_rem_q <= sel_rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed cases plus random ops
// checked against an arithmetic reference of the RV32M divide rules.
module tb_div_sequencer;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        start = 1'b0;
    logic        kill = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] opa = '0;
    logic [31:0] opb = '0;
    logic        stall, busy, done;
    logic [31:0] result;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [31:0] last_result = '0;

    div_sequencer dut (
        .clk    (clk),
        .nrst   (nrst),
        .start  (start),
        .op     (op),
        .opa    (opa),
        .opb    (opb),
        .kill   (kill),
        .stall  (stall),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        if (b == 0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return o[1] ? 32'h0 : 32'h8000_0000;
        if (!o[0]) begin
            sa = int'(a);
            sb = int'(b);
            return o[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return o[1] ? (a % b) : (a / b);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int done_cyc);
        int exp_lat;
        logic [31:0] exp_res;
        bit seen;
        exp_res  = model(o, a, b);
        exp_lat  = (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
        done_cyc = -1;
        tick();
        start = 1'b1; op = o; opa = a; opb = b;
        #1;
        check("c0_stall", stall, 1);
        check("c0_done", done, 0);
        seen = 0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            tick();
            opa = $urandom;
            opb = $urandom;
            #1;
            if (done) begin
                seen = 1;
                check("latency", c, exp_lat);
                check("result", result, exp_res);
                check("done_stall", stall, 0);
                check("done_busy", busy, 1);
                done_cyc    = cyc;
                last_result = exp_res;
            end else begin
                check("busy_stall", stall, 1);
                check("busy_flag", busy, 1);
            end
        end
        if (!seen) check("timeout_done", done, 1);
    endtask

    task automatic idle_cycle();
        tick();
        start = 1'b0;
        #1;
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_stall", stall, 0);
        check("held_result", result, last_result);
    endtask

    initial begin
        int d1, d2, dummy;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        #1 nrst = 1'b1;
        #2;
        check("rst_stall", stall, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        repeat (2) @(posedge clk);
        #2 nrst = 1'b0;

        run_op(2'b01, 32'd100, 32'd7, dummy);            idle_cycle();
        run_op(2'b10, 32'hFFFF_FF9C, 32'd7, dummy);      idle_cycle();
        run_op(2'b00, 32'hFFFF_FF9C, 32'd7, dummy);      idle_cycle();
        run_op(2'b01, 32'd5, 32'd0, dummy);              idle_cycle();
        run_op(2'b11, 32'd5, 32'd0, dummy);              idle_cycle();

        // kill in BUSY at cycle 10
        tick();
        start = 1'b1; op = 2'b00; opa = 32'd100; opb = 32'd7;
        #1 check("kill_c0_stall", stall, 1);
        for (int c = 1; c < 10; c++) tick();
        kill = 1'b1;
        #1;
        check("kill_stall", stall, 0);
        check("kill_done", done, 0);
        tick();
        kill = 1'b0; start = 1'b0;
        #1;
        check("kill_busy", busy, 0);
        check("kill_nodone", done, 0);
        check("kill_result", result, last_result);
        run_op(2'b01, 32'd9, 32'd3, dummy);              idle_cycle();

        // start together with kill in IDLE is ignored
        tick();
        start = 1'b1; kill = 1'b1; op = 2'b01; opa = 32'd50; opb = 32'd5;
        #1 check("sk_stall", stall, 0);
        tick();
        start = 1'b0; kill = 1'b0;
        #1 check("sk_busy", busy, 0);

        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, dummy); idle_cycle();
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, dummy); idle_cycle();

        // asynchronous reset in the middle of BUSY
        tick();
        start = 1'b1; op = 2'b01; opa = 32'd100; opb = 32'd7;
        for (int c = 1; c <= 5; c++) tick();
        nrst = 1'b1; start = 1'b0;
        #1;
        check("arst_stall", stall, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_result", result, 0);
        last_result = '0;
        #1 nrst = 1'b0;
        idle_cycle();

        // back-to-back
        run_op(2'b01, 32'd8, 32'd2, d1);
        run_op(2'b11, 32'd8, 32'd3, d2);
        check("b2b_gap", d2 - d1, 34);
        idle_cycle();

        // random ops, sometimes back-to-back
        for (int k = 0; k < 24; k++) begin
            ro = 2'($urandom);
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = $urandom_range(1, 15);
                3: ra = $urandom_range(0, 255);
                4: rb = 32'hFFFF_FFFF - $urandom_range(0, 15);
                default: ;
            endcase
            run_op(ro, ra, rb, dummy);
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end
        idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
